// File: rtl/bidir_shift_engine_if.sv
// Command/data bundle for bidir_shift_engine: the initiator drives commands
// and serial fill bits, the engine returns its register, serial out and handshake.
interface bidir_shift_engine_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH + 1);

    logic             clear;
    logic             en;
    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] din;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output clear, en, start, op, amt, din, sin_l, sin_r,
        input  dout, sout, busy, done
    );

    modport slave (
        input  clear, en, start, op, amt, din, sin_l, sin_r,
        output dout, sout, busy, done
    );
endinterface

// File: rtl/bidir_shift_engine.sv
// Sequential WIDTH-bit shifter: load, logical/arithmetic shift and rotate,
// one bit position per enabled clock, behind a start/busy/done handshake.
module bidir_shift_engine #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bidir_shift_engine_if.slave  bus
);
    localparam int AW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SAR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_dout,   w_dout_nxt;
    logic             r_sout,   w_sout_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic [AW-1:0]    r_count,  w_count_nxt;
    logic [2:0]       r_op,     w_op_nxt;

    logic [WIDTH-1:0] w_step_dout;
    logic             w_step_sout;

    // One step of the latched operation applied to the current register.
    always_comb begin
        w_step_dout = r_dout;
        w_step_sout = r_sout;
        case (r_op)
            OP_SHL: begin
                w_step_sout = r_dout[WIDTH-1];
                w_step_dout = {r_dout[WIDTH-2:0], bus.sin_l};
            end
            OP_SHR: begin
                w_step_sout = r_dout[0];
                w_step_dout = {bus.sin_r, r_dout[WIDTH-1:1]};
            end
            OP_SAR: begin
                w_step_sout = r_dout[0];
                w_step_dout = {r_dout[WIDTH-1], r_dout[WIDTH-1:1]};
            end
            OP_ROL: begin
                w_step_sout = r_dout[WIDTH-1];
                w_step_dout = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
            end
            OP_ROR: begin
                w_step_sout = r_dout[0];
                w_step_dout = {r_dout[0], r_dout[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_dout_nxt  = r_dout;
        w_sout_nxt  = r_sout;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;

        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            w_dout_nxt  = '0;
            w_sout_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_count_nxt = '0;
        end else if (bus.en) begin
            w_done_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_op_nxt = bus.op;
                        case (bus.op)
                            OP_LOAD: begin
                                w_dout_nxt = bus.din;
                                w_done_nxt = 1'b1;
                            end
                            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                                if (bus.amt == '0) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_count_nxt = bus.amt;
                                    w_busy_nxt  = 1'b1;
                                    w_state_nxt = S_SHIFT;
                                end
                            end
                            default: w_done_nxt = 1'b1;
                        endcase
                    end
                end
                S_SHIFT: begin
                    w_dout_nxt  = w_step_dout;
                    w_sout_nxt  = w_step_sout;
                    w_count_nxt = r_count - AW'(1);
                    // Completing step: the start edge already counted as zero latency.
                    if (r_count == AW'(1)) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dout  <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dout  <= w_dout_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign bus.dout = r_dout;
    assign bus.sout = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_bidir_shift_engine.sv
// Directed and randomized checks of bidir_shift_engine (WIDTH=8) against a
// closed-form reference model of each shift/rotate operation.
module tb_bidir_shift_engine;
    localparam int W = 8;

    localparam logic [2:0] LOAD = 3'b000;
    localparam logic [2:0] SHL  = 3'b001;
    localparam logic [2:0] SHR  = 3'b010;
    localparam logic [2:0] SAR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] NOP  = 3'b111;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    bidir_shift_engine_if #(.WIDTH(W)) bus ();

    bidir_shift_engine #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input int amt, input logic [W-1:0] din);
        bus.start = 1'b1;
        bus.op    = op;
        bus.amt   = 4'(amt);
        bus.din   = din;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc, output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'(1));
    endtask

    // Result of a whole n-step operation, from shift/rotate arithmetic on a double-width word.
    task automatic model(input logic [2:0] op, input int n, input logic fill,
                         input logic [W-1:0] v, inout logic [W-1:0] r, inout logic s);
        logic [2*W-1:0] x, t, u;
        if (n == 0) return;
        case (op)
            SHL:     x = {v, {W{fill}}};
            SHR:     x = {{W{fill}}, v};
            SAR:     x = {{W{v[W-1]}}, v};
            default: x = {v, v};
        endcase
        if (op == SHL || op == ROL) begin
            t = x << n;
            u = x << (n - 1);
            r = t[2*W-1:W];
            s = u[2*W-1];
        end else begin
            t = x >> n;
            u = x >> (n - 1);
            r = t[W-1:0];
            s = u[0];
        end
    endtask

    initial begin
        int             cyc;
        logic [W-1:0]   v, m_dout;
        logic           m_sout, f;
        logic [2:0]     op;
        int             n;

        rst_n     = 1'b0;
        bus.clear = 1'b0;
        bus.en    = 1'b1;
        bus.start = 1'b0;
        bus.op    = LOAD;
        bus.amt   = '0;
        bus.din   = '0;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        #1;
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_sout", 64'(bus.sout), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a shift.
        issue(LOAD, 0, 8'hFF);
        issue(SHL, 5, 8'h00);
        tick();
        tick();
        check("midrst_busy_before", 64'(bus.busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 64'(bus.dout), 64'(0));
        check("midrst_sout", 64'(bus.sout), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // LOAD
        issue(LOAD, 0, 8'hA5);
        check("load_dout", 64'(bus.dout), 64'hA5);
        check("load_done", 64'(bus.done), 64'(1));
        check("load_busy", 64'(bus.busy), 64'(0));
        tick();
        check("load_done_clr", 64'(bus.done), 64'(0));
        check("load_busy_after", 64'(bus.busy), 64'(0));

        // SHL by 3 with sin_l=1
        bus.sin_l = 1'b1;
        issue(SHL, 3, 8'h00);
        check("shl_busy0", 64'(bus.busy), 64'(1));
        check("shl_dout0", 64'(bus.dout), 64'hA5);
        tick();
        check("shl_dout1", 64'(bus.dout), 64'h4B);
        check("shl_sout1", 64'(bus.sout), 64'(1));
        check("shl_busy1", 64'(bus.busy), 64'(1));
        tick();
        check("shl_dout2", 64'(bus.dout), 64'h97);
        check("shl_sout2", 64'(bus.sout), 64'(0));
        check("shl_done2", 64'(bus.done), 64'(0));
        tick();
        check("shl_dout3", 64'(bus.dout), 64'h2F);
        check("shl_sout3", 64'(bus.sout), 64'(1));
        check("shl_busy3", 64'(bus.busy), 64'(0));
        check("shl_done3", 64'(bus.done), 64'(1));
        bus.sin_l = 1'b0;

        // SAR by 2 on 0x90
        issue(LOAD, 0, 8'h90);
        issue(SAR, 2, 8'h00);
        tick();
        check("sar_dout1", 64'(bus.dout), 64'hC8);
        check("sar_sout1", 64'(bus.sout), 64'(0));
        tick();
        check("sar_dout2", 64'(bus.dout), 64'hE4);
        check("sar_sout2", 64'(bus.sout), 64'(0));
        check("sar_done", 64'(bus.done), 64'(1));

        // ROR by full width returns the original value
        issue(LOAD, 0, 8'h3C);
        issue(ROR, 8, 8'h00);
        wait_done("ror8", 12, cyc);
        check("ror8_lat", 64'(cyc), 64'(8));
        check("ror8_dout", 64'(bus.dout), 64'h3C);

        // SHR by full width with sin_r=0
        bus.sin_r = 1'b0;
        issue(LOAD, 0, 8'hFF);
        issue(SHR, 8, 8'h00);
        wait_done("shr8", 12, cyc);
        check("shr8_lat", 64'(cyc), 64'(8));
        check("shr8_dout", 64'(bus.dout), 64'h00);
        check("shr8_sout", 64'(bus.sout), 64'(1));

        // amt=0 and NOP leave the register alone
        issue(LOAD, 0, 8'h5A);
        issue(SHL, 0, 8'h00);
        check("amt0_done", 64'(bus.done), 64'(1));
        check("amt0_busy", 64'(bus.busy), 64'(0));
        check("amt0_dout", 64'(bus.dout), 64'h5A);
        issue(NOP, 3, 8'hFF);
        check("nop_done", 64'(bus.done), 64'(1));
        check("nop_busy", 64'(bus.busy), 64'(0));
        check("nop_dout", 64'(bus.dout), 64'h5A);
        tick();
        check("nop_done_clr", 64'(bus.done), 64'(0));

        // start while busy is ignored
        issue(LOAD, 0, 8'h12);
        issue(ROL, 4, 8'h00);
        tick();
        issue(LOAD, 0, 8'h00);
        check("ign_busy", 64'(bus.busy), 64'(1));
        tick();
        tick();
        check("ign_done", 64'(bus.done), 64'(1));
        check("ign_dout", 64'(bus.dout), 64'h21);

        // clear at step 2 of ROL by 5
        issue(LOAD, 0, 8'h81);
        issue(ROL, 5, 8'h00);
        tick();
        check("clr_step1", 64'(bus.dout), 64'h03);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_dout", 64'(bus.dout), 64'(0));
        check("clr_busy", 64'(bus.busy), 64'(0));
        check("clr_sout", 64'(bus.sout), 64'(0));
        for (int i = 0; i < 5; i++) begin
            check("clr_no_done", 64'(bus.done), 64'(0));
            tick();
        end

        // en=0 gap of 3 cycles mid-SHL
        bus.sin_l = 1'b1;
        issue(LOAD, 0, 8'hA5);
        issue(SHL, 3, 8'h00);
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_hold_dout", 64'(bus.dout), 64'h4B);
            check("gap_hold_busy", 64'(bus.busy), 64'(1));
        end
        bus.en = 1'b1;
        tick();
        check("gap_not_done", 64'(bus.done), 64'(0));
        tick();
        check("gap_done", 64'(bus.done), 64'(1));
        check("gap_dout", 64'(bus.dout), 64'h2F);
        bus.en = 1'b0;
        tick();
        check("gap_done_stretch", 64'(bus.done), 64'(1));
        bus.en = 1'b1;
        tick();
        check("gap_done_clr", 64'(bus.done), 64'(0));
        bus.sin_l = 1'b0;

        // Back-to-back commands issued in each done cycle
        issue(LOAD, 0, 8'h01);
        check("b2b_load", 64'(bus.dout), 64'h01);
        check("b2b_load_done", 64'(bus.done), 64'(1));
        issue(ROL, 1, 8'h00);
        check("b2b_rol_busy", 64'(bus.busy), 64'(1));
        tick();
        check("b2b_rol_dout", 64'(bus.dout), 64'h02);
        check("b2b_rol_done", 64'(bus.done), 64'(1));
        issue(SHL, 1, 8'h00);
        check("b2b_shl_busy", 64'(bus.busy), 64'(1));
        tick();
        check("b2b_shl_dout", 64'(bus.dout), 64'h04);
        check("b2b_shl_done", 64'(bus.done), 64'(1));

        // Randomized operations against the closed-form model
        m_sout = 1'b0;
        for (int k = 0; k < 30; k++) begin
            v  = W'($urandom);
            op = 3'($urandom_range(1, 5));
            n  = $urandom_range(0, W);
            f  = 1'($urandom_range(0, 1));
            bus.sin_l = f;
            bus.sin_r = f;
            m_dout = v;
            model(op, n, f, v, m_dout, m_sout);
            issue(LOAD, 0, v);
            issue(op, n, 8'h00);
            if (n > 0) check("rnd_busy", 64'(bus.busy), 64'(1));
            wait_done("rnd", W + 4, cyc);
            check("rnd_lat", 64'(cyc), 64'(n));
            check("rnd_dout", 64'(bus.dout), 64'(m_dout));
            check("rnd_sout", 64'(bus.sout), 64'(m_sout));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
